// File: rtl/testport_pkg.sv
// Shared constants, FSM state type and helpers for the test-port monitor.
package testport_pkg;

    localparam logic [29:0] TEST_PORT_DEF    = 30'h3FF;
    localparam logic [31:0] BEGIN_SYMBOL_DEF = 32'h0000_0168;
    localparam logic [31:0] END_SYMBOL_DEF   = 32'hFFFF_FD5D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Store data arrives little-endian; symbols and results are kept in readable order.
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/testport_monitor_if.sv
// Data-memory write snoop bus plus the result stream toward the checker.
interface testport_monitor_if;

    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (
        output addr, data, wen, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  addr, data, wen, out_ready,
        output out_valid, out_data
    );

endinterface

// File: rtl/testport_fifo.sv
// Synchronous FIFO with registered storage; the head word is visible one cycle after its push.
module testport_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot the write pointer already addresses.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/testport_monitor.sv
// Snoops stores to the test port, frames a session between BEGIN/END symbols and queues its words.
module testport_monitor
    import testport_pkg::*;
#(
    parameter logic [29:0] TEST_PORT    = TEST_PORT_DEF,
    parameter logic [31:0] BEGIN_SYMBOL = BEGIN_SYMBOL_DEF,
    parameter logic [31:0] END_SYMBOL   = END_SYMBOL_DEF,
    parameter int unsigned DEPTH        = 4
) (
    input  logic               clk,
    input  logic               rst,
    testport_monitor_if.slave  bus,
    output logic               armed,
    output logic               done,
    output logic               overflow,
    output logic [15:0]        duration
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    state_t          state;
    state_t          state_next;
    logic            prev_wen;
    logic [31:0]     wdata;
    logic            qualified;
    logic            capture;
    logic            push;
    logic            pop;
    logic            drop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    assign wdata     = byte_swap(bus.data);
    assign qualified = bus.wen && (bus.addr == TEST_PORT);
    // A cache stall holds wen high; only the rising edge of a qualified write is a capture.
    assign capture   = qualified && !prev_wen;
    assign pop       = bus.out_valid && bus.out_ready;
    assign drop      = push && fifo_full && !pop;

    assign armed         = (state == ARMED);
    assign done          = (state == DONE);
    assign bus.out_valid = !fifo_empty;

    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (capture && (wdata == BEGIN_SYMBOL)) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (capture) begin
                    push = 1'b1;
                    if (wdata == END_SYMBOL) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prev_wen <= 1'b0;
            overflow <= 1'b0;
            duration <= '0;
        end else begin
            state    <= state_next;
            prev_wen <= bus.wen;
            if (drop) begin
                overflow <= 1'b1;
            end
            if ((state == IDLE) && (state_next == ARMED)) begin
                duration <= '0;
            end else if ((state == ARMED) && (duration != '1)) begin
                duration <= duration + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_full == (fifo_count == FULL_COUNT) && fifo_empty == (fifo_count == '0))
                else $error("testport_fifo flags disagree with occupancy %0d", fifo_count);
        end
    end

    testport_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wdata),
        .rd_data (bus.out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_testport_monitor.sv
// Directed bench for testport_monitor: expected result words queued at drive time, checked at pop.
module tb_testport_monitor;

    localparam logic [29:0] PORT   = 30'h3FF;
    localparam logic [31:0] BEGIN_LE = 32'h6801_0000;
    localparam logic [31:0] END_LE   = 32'h5DFD_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        armed;
    logic        done;
    logic        overflow;
    logic [15:0] duration;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pops     = 0;
    logic [31:0] last_pop = '0;
    logic [31:0] exp_word;
    logic [31:0] sb [$];

    testport_monitor_if tif ();

    testport_monitor #(
        .TEST_PORT    (PORT),
        .BEGIN_SYMBOL (32'h0000_0168),
        .END_SYMBOL   (32'hFFFF_FD5D),
        .DEPTH        (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (tif),
        .armed    (armed),
        .done     (done),
        .overflow (overflow),
        .duration (duration)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sw(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [29:0] a, input logic [31:0] d, input int unsigned hold);
        tif.addr = a;
        tif.data = d;
        tif.wen  = 1'b1;
        repeat (hold) tick();
        tif.wen  = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        tif.out_ready = 1'b1;
        while (sb.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        check(tag, sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    // Handshakes complete at the next rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (!rst && tif.out_valid && tif.out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_pop", {31'b0, tif.out_valid}, 32'd0);
            end else begin
                exp_word = sb.pop_front();
                check("pop_data", tif.out_data, exp_word);
                pops++;
                last_pop = tif.out_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] answers [6];
        answers = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0};

        rst           = 1'b1;
        tif.addr      = '0;
        tif.data      = '0;
        tif.wen       = 1'b0;
        tif.out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", {31'b0, tif.out_valid}, 32'd0);
        check("rst_out_data",  tif.out_data, 32'd0);
        check("rst_armed",     {31'b0, armed}, 32'd0);
        check("rst_done",      {31'b0, done}, 32'd0);
        check("rst_overflow",  {31'b0, overflow}, 32'd0);
        check("rst_duration",  {16'b0, duration}, 32'd0);
        rst = 1'b0;

        // Non-BEGIN data at the port, BEGIN at a neighbouring address.
        tif.out_ready = 1'b1;
        write_word(PORT, 32'h4433_2211, 1);
        write_word(PORT, 32'h0000_0000, 1);
        write_word(30'h3FE, BEGIN_LE, 1);
        check("idle_armed",     {31'b0, armed}, 32'd0);
        check("idle_out_valid", {31'b0, tif.out_valid}, 32'd0);

        // Stalled BEGIN write held three cycles counts once.
        tif.addr = PORT;
        tif.data = BEGIN_LE;
        tif.wen  = 1'b1;
        tick();
        check("stall_armed_first", {31'b0, armed}, 32'd1);
        tick();
        tick();
        tif.wen = 1'b0;
        tick();
        check("stall_no_push", {31'b0, tif.out_valid}, 32'd0);
        pops = 0;
        sb.push_back(32'h0000_0000);
        write_word(PORT, 32'h0000_0000, 1);
        drain("stall_drain");
        check("stall_pop_count", pops, 32'd1);

        // Full session: six answers then END, checker always ready.
        do_reset();
        pops = 0;
        tif.out_ready = 1'b1;
        write_word(PORT, BEGIN_LE, 1);
        for (int i = 0; i < 6; i++) begin
            sb.push_back(answers[i]);
            write_word(PORT, sw(answers[i]), 1);
        end
        sb.push_back(32'hFFFF_FD5D);
        write_word(PORT, END_LE, 1);
        drain("session_drain");
        check("session_pop_count", pops, 32'd7);
        check("session_last",      last_pop, 32'hFFFF_FD5D);
        check("session_done",      {31'b0, done}, 32'd1);
        check("session_armed",     {31'b0, armed}, 32'd0);
        check("session_overflow",  {31'b0, overflow}, 32'd0);
        check("session_duration",  {16'b0, duration}, 32'd14);
        write_word(PORT, BEGIN_LE, 1);
        write_word(PORT, 32'h1111_1111, 1);
        check("done_sticky",       {31'b0, done}, 32'd1);
        check("done_ignores",      {31'b0, tif.out_valid}, 32'd0);
        check("done_duration_hold", {16'b0, duration}, 32'd14);

        // Overflow: five captures with the checker stalled.
        do_reset();
        pops = 0;
        tif.out_ready = 1'b0;
        write_word(PORT, BEGIN_LE, 1);
        for (int i = 1; i <= 4; i++) begin
            sb.push_back(sw(32'hA000_0000 + 32'(i)));
            write_word(PORT, 32'hA000_0000 + 32'(i), 1);
        end
        check("ovf_before_fifth", {31'b0, overflow}, 32'd0);
        write_word(PORT, 32'hA000_0005, 1);
        check("ovf_set",       {31'b0, overflow}, 32'd1);
        check("ovf_out_valid", {31'b0, tif.out_valid}, 32'd1);
        check("ovf_head",      tif.out_data, sw(32'hA000_0001));
        tick();
        tick();
        check("ovf_head_stable", tif.out_data, sw(32'hA000_0001));
        drain("ovf_drain");
        check("ovf_pop_count", pops, 32'd4);

        // Full FIFO, capture in the same cycle as a pop.
        do_reset();
        pops = 0;
        tif.out_ready = 1'b0;
        write_word(PORT, BEGIN_LE, 1);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(sw(32'hB000_0000 + 32'(i)));
            write_word(PORT, 32'hB000_0000 + 32'(i), 1);
        end
        sb.push_back(sw(32'hB000_0004));
        tif.addr      = PORT;
        tif.data      = 32'hB000_0004;
        tif.wen       = 1'b1;
        tif.out_ready = 1'b1;
        tick();
        tif.out_ready = 1'b0;
        tif.wen       = 1'b0;
        tick();
        check("simul_overflow", {31'b0, overflow}, 32'd0);
        check("simul_head",     tif.out_data, sw(32'hB000_0001));
        write_word(PORT, 32'hB000_0005, 1);
        check("simul_still_full", {31'b0, overflow}, 32'd1);
        drain("simul_drain");
        check("simul_pop_count", pops, 32'd5);

        // Reset mid-session with words queued and wen held high across reset.
        do_reset();
        pops = 0;
        tif.out_ready = 1'b0;
        write_word(PORT, BEGIN_LE, 1);
        write_word(PORT, 32'hC000_0001, 1);
        write_word(PORT, 32'hC000_0002, 1);
        check("mid_queued", {31'b0, tif.out_valid}, 32'd1);
        tif.addr = 30'h3FE;
        tif.wen  = 1'b1;
        tick();
        tif.addr = PORT;
        tif.data = BEGIN_LE;
        rst      = 1'b1;
        tick();
        sb.delete();
        check("mid_rst_out_valid", {31'b0, tif.out_valid}, 32'd0);
        check("mid_rst_armed",     {31'b0, armed}, 32'd0);
        check("mid_rst_duration",  {16'b0, duration}, 32'd0);
        rst = 1'b0;
        tick();
        check("mid_rearm", {31'b0, armed}, 32'd1);
        tif.wen = 1'b0;
        tick();
        check("mid_rearm_empty", {31'b0, tif.out_valid}, 32'd0);
        sb.push_back(sw(32'hD000_0001));
        write_word(PORT, 32'hD000_0001, 1);
        drain("mid_drain");
        check("mid_pop_count", pops, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/testport_monitor.md
TESTPORT_MONITOR -- requirements
Module: testport_monitor

Interface
REQ-001 Parameter TEST_PORT, default 30'h3FF, word address of the test port.
REQ-002 Parameter BEGIN_SYMBOL, default 32'h00000168, value (readable order) that opens a session.
REQ-003 Parameter END_SYMBOL, default 32'hFFFFFD5D, value (readable order) that closes a session.
REQ-004 Parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 addr  input  30  word address of the data-memory access.
REQ-008 data  input  32  write data, little-endian byte order.
REQ-009 wen  input  1  write enable; stays high for multiple cycles during a cache stall.
REQ-010 out_valid  output  1  FIFO head holds a result word.
REQ-011 out_data  output  32  FIFO head word, readable byte order.
REQ-012 out_ready  input  1  downstream checker accepts head word.
REQ-013 armed  output  1  session open (BEGIN seen, END not yet captured).
REQ-014 done  output  1  END_SYMBOL captured; sticky until reset.
REQ-015 overflow  output  1  sticky: a capture was dropped because the FIFO was full.
REQ-016 duration  output  16  cycles spent in ARMED, saturating at 16'hFFFF.

Function
REQ-017 Byte swap SHALL be wdata = {data[7:0],data[15:8],data[23:16],data[31:24]}.
REQ-018 Qualified write SHALL be wen && addr==TEST_PORT; a capture event SHALL occur only on the first cycle of a qualified write (qualified now, wen low the previous cycle), so a stalled write counts once.
REQ-019 FSM states SHALL be IDLE, ARMED, DONE; reset state IDLE.
REQ-020 IDLE: capture with wdata==BEGIN_SYMBOL -> ARMED, nothing pushed; any other capture ignored.
REQ-021 ARMED: every capture SHALL push wdata; capture with wdata==END_SYMBOL pushes it and -> DONE.
REQ-022 DONE: all captures ignored; stays in DONE until reset.
REQ-023 A push SHALL be accepted when occupancy<DEPTH, or when full and a pop occurs in the same cycle; otherwise the word is dropped and overflow set. An END_SYMBOL drop still moves the FSM to DONE.
REQ-024 Pop SHALL occur when out_valid && out_ready; simultaneous push and pop keep occupancy unchanged.
REQ-025 Push-to-out_valid latency SHALL be 1 cycle (no fall-through); out_data SHALL be stable while out_valid && !out_ready.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; occupancy held in a log2(DEPTH)+1-bit counter.
REQ-027 duration SHALL clear on entering ARMED, increment each ARMED cycle, saturate at 16'hFFFF, and hold in DONE.
REQ-028 armed = (state==ARMED); done = (state==DONE); FIFO continues draining in DONE.

Reset
REQ-029 On rst high at a clock edge: state IDLE, FIFO empty, out_valid 0, out_data 0, armed 0, done 0, overflow 0, duration 0, previous-wen register 0.
REQ-030 Reset mid-session SHALL discard FIFO contents; the first qualified write after reset SHALL count as a new capture even if wen was high before reset.

Structure
REQ-031 Shared package testport_pkg SHALL hold TEST_PORT, BEGIN_SYMBOL, END_SYMBOL defaults and the IDLE/ARMED/DONE state type.
REQ-032 FIFO SHALL be a sub-module testport_fifo (DEPTH, 32-bit, push/pop/full/empty/count); FSM, edge detect, byte swap in the top.

Verification
REQ-033 Write 32'h68010000 to 3FF with wen high 3 cycles, then 32'h00000000 -> armed=1 after first write, exactly one word 32'h00000000 popped.
REQ-034 Session with answers 0,1,1,1,1,0 then END (data 32'h5DFDFFFF), out_ready=1 -> seven words out in order, last 32'hFFFFFD5D, done=1, overflow=0.
REQ-035 out_ready=0, DEPTH=4, five captures in ARMED -> first four retained, fifth dropped, overflow=1, out_valid held with first word.
REQ-036 FIFO full, capture in same cycle as pop -> push accepted, occupancy stays 4, no overflow.
REQ-037 Non-BEGIN writes to 3FF and BEGIN written to 3FE in IDLE -> armed stays 0, out_valid stays 0.
REQ-038 rst pulsed with 2 words queued and wen high -> FIFO empty, state IDLE, duration 0; next BEGIN capture re-arms.
